branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 64, number of table entries; SHALL be a power of two, 4..1024.
REQ-002 Parameter: TAG_W, 8, tag bits stored per entry, taken from pc[TAG_W+IDX+1:IDX+2], where IDX = log2(ENTRIES).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: if_pc  in  32  fetch PC to look up.
REQ-006 Port: if_valid  in  1  lookup request.
REQ-007 Port: pred_taken  out  1  lookup result: predict taken.
REQ-008 Port: pred_pc  out  32  predicted next PC.
REQ-009 Port: pred_valid  out  1  pred_taken/pred_pc valid.
REQ-010 Port: branch_ex  in  1  branch/jump resolving this cycle.
REQ-011 Port: ex_pc  in  32  PC of resolving instruction.
REQ-012 Port: jump_pc, njump_pc  in  32 each  resolved taken target; fall-through PC.
REQ-013 Port: branch_taken  in  1  resolved direction.
REQ-014 Port: ex_pred_taken, ex_pred_pc  in  1, 32  prediction carried with the resolving instruction.
REQ-015 Port: flush  out  1  misprediction redirect pulse.
REQ-016 Port: new_pc  out  32  redirect target, valid while flush=1.

Function
REQ-017 Table: ENTRIES entries of {valid, tag[TAG_W], target[31:2], ctr[1:0]}; index = pc[IDX+1:2].
REQ-018 Lookup latency: exactly 1 cycle; if_valid at cycle N -> pred_valid=1 at N+1; pred_valid=0 at N+1 when if_valid=0 at N.
REQ-019 Hit when entry valid and tag matches; on hit, pred_taken = ctr[1] and pred_pc = {target,2'b00} if ctr[1], else if_pc(N)+4.
REQ-020 On miss: pred_taken=0, pred_pc=if_pc(N)+4; the +4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 Mispredict = branch_ex & ((branch_taken != ex_pred_taken) | (branch_taken & ex_pred_taken & jump_pc != ex_pred_pc)).
REQ-022 flush SHALL be registered: asserted for exactly the one cycle after a mispredict; new_pc = jump_pc if branch_taken, else njump_pc, captured in the same cycle.
REQ-023 Counter update on branch_ex with hit: taken increments, not-taken decrements, saturating at 3 and 0; target <= jump_pc[31:2] when taken.
REQ-024 Allocation on branch_ex with miss and branch_taken: write valid=1, new tag, target, ctr=2'b10; a not-taken miss SHALL NOT allocate.
REQ-025 Simultaneous lookup and update of the same index in one cycle: the lookup SHALL return the pre-update entry; the update SHALL complete.
REQ-026 Back-to-back branch_ex on consecutive cycles SHALL each update the table and may each raise flush; no request SHALL be dropped.

Reset
REQ-027 While rst=1: all valid bits cleared, flush=0, pred_valid=0, new_pc=0, pred_taken=0, pred_pc=0.
REQ-028 rst asserted mid-operation SHALL cancel any pending flush; the first lookup after rst deasserts SHALL miss.

Configuration
REQ-029 Macro BRANCH_PREDICTOR_STATS_EN: when defined, adds output mispredict_count[31:0], cleared by rst, incremented by 1 per mispredict (wrapping at 2^32) in the cycle flush asserts.
REQ-030 Without BRANCH_PREDICTOR_STATS_EN: no port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then lookup if_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_pc=0x104.
REQ-032 Resolve ex_pc=0x100, taken, jump_pc=0x200, ex_pred_taken=0 -> flush=1 for one cycle, new_pc=0x200; a later lookup of 0x100 -> pred_taken=1, pred_pc=0x200.
REQ-033 Three not-taken resolves of 0x100 after allocation -> ctr 2->1->0->0 (saturates), lookup gives pred_pc=0x104; each resolve with ex_pred_taken matching ctr[1] before the update raises no flush.
REQ-034 Taken, correct direction but ex_pred_pc=0x200 while jump_pc=0x300 -> flush=1, new_pc=0x300; table target becomes 0x300.
REQ-035 Same-cycle lookup and update of 0x100 -> lookup returns the old entry; a lookup one cycle later returns the new one. Lookup of 0xFFFFFFFC on a miss -> pred_pc=0x0.
REQ-036 With BRANCH_PREDICTOR_STATS_EN defined, 5 mispredicts then rst pulse -> mispredict_count reads 5, then 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional build macro BRANCH_PREDICTOR_STATS_EN adds a mispredict_count output.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    output logic        pred_valid,
    input  logic        branch_ex,
    input  logic [31:0] ex_pc,
    input  logic [31:0] jump_pc,
    input  logic [31:0] njump_pc,
    input  logic        branch_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_pc,
    output logic        flush,
    output logic [31:0] new_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] mispredict_count
`endif
);
    localparam int IDX = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [29:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    logic [IDX-1:0]   if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             if_taken;
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr;
    logic [1:0]       ctr_next;
    logic             alloc;
    logic             mispredict;

    logic             pred_taken_reg;
    logic [31:0]      pred_pc_reg;
    logic             pred_valid_reg;
    logic             flush_reg;
    logic [31:0]      new_pc_reg;

    // Only the index/tag slices of the PCs feed the table; fold the rest here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, ex_pc};

    assign if_idx   = if_pc[IDX+1:2];
    assign if_tag   = if_pc[TAG_W+IDX+1:IDX+2];
    assign if_hit   = valid_reg[if_idx] && (tag_mem[if_idx] == if_tag);
    assign if_taken = if_hit && ctr_mem[if_idx][1];

    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[TAG_W+IDX+1:IDX+2];
    assign ex_hit = valid_reg[ex_idx] && (tag_mem[ex_idx] == ex_tag);
    assign ex_ctr = ctr_mem[ex_idx];
    assign alloc  = branch_ex && !ex_hit && branch_taken;

    assign mispredict = branch_ex &&
        ((branch_taken != ex_pred_taken) ||
         (branch_taken && ex_pred_taken && (jump_pc != ex_pred_pc)));

    always_comb begin
        ctr_next = ex_ctr;
        if (branch_taken) begin
            if (ex_ctr != 2'b11) ctr_next = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ctr_next = ex_ctr - 2'b01;
        end
    end

    // Lookup reads the table before this edge's update lands, so a same-cycle
    // update of the same index is invisible until the following lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_pc_reg    <= 32'h0;
        end else begin
            pred_valid_reg <= if_valid;
            pred_taken_reg <= if_valid && if_taken;
            if (if_valid) begin
                pred_pc_reg <= if_taken ? {target_mem[if_idx], 2'b00} : (if_pc + 32'd4);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (alloc && (ex_idx == IDX'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (branch_ex) begin
            if (ex_hit) begin
                ctr_mem[ex_idx] <= ctr_next;
                if (branch_taken) target_mem[ex_idx] <= jump_pc[31:2];
            end else if (branch_taken) begin
                tag_mem[ex_idx]    <= ex_tag;
                target_mem[ex_idx] <= jump_pc[31:2];
                ctr_mem[ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'h0;
        end else begin
            flush_reg <= mispredict;
            if (mispredict) new_pc_reg <= branch_taken ? jump_pc : njump_pc;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] mispredict_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_count_reg <= 32'h0;
        end else if (mispredict) begin
            mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign mispredict_count = mispredict_count_reg;
`endif

    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_pc    = pred_pc_reg;
    assign flush      = flush_reg;
    assign new_pc     = new_pc_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic
// checked against a table-level reference model.
module tb_branch_predictor;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int IDX     = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        if_valid = 1'b0;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        branch_ex = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] jump_pc = '0;
    logic [31:0] njump_pc = '0;
    logic        branch_taken = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_pc = '0;
    logic        flush;
    logic [31:0] new_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] mispredict_count;
`endif

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_valid(pred_valid),
        .branch_ex(branch_ex), .ex_pc(ex_pc), .jump_pc(jump_pc), .njump_pc(njump_pc),
        .branch_taken(branch_taken), .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .flush(flush), .new_pc(new_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
        , .mispredict_count(mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          pv;
        bit          pt;
        logic [31:0] ppc;
        bit          fl;
        logic [31:0] npc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference model: one record per table slot, plain integer counters.
    bit          m_valid  [ENTRIES];
    int          m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_newpc = '0;
    logic [31:0] m_cnt = '0;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> (IDX + 2)) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    task automatic m_predict(input logic [31:0] pc, output bit t, output logic [31:0] npc);
        if (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) begin
            t = 1'b1;
            npc = m_target[m_idx(pc)];
        end else begin
            t = 1'b0;
            npc = pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit iv, input logic [31:0] ip,
                        input bit bx, input logic [31:0] xp, input logic [31:0] jp,
                        input logic [31:0] njp, input bit bt, input bit ept,
                        input logic [31:0] epp);
        exp_t e;
        bit mis;
        int i;
        @(negedge clk);
        rst = r; if_valid = iv; if_pc = ip; branch_ex = bx; ex_pc = xp;
        jump_pc = jp; njump_pc = njp; branch_taken = bt;
        ex_pred_taken = ept; ex_pred_pc = epp;
        e = '{rst: r, pv: 0, pt: 0, ppc: 0, fl: 0, npc: 0, cnt: 0};
        if (r) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            m_newpc = '0;
            m_cnt = '0;
        end else begin
            e.pv = iv;
            if (iv) m_predict(ip, e.pt, e.ppc);
            mis = bx && ((bt != ept) || (bt && ept && jp != epp));
            if (mis) begin
                m_newpc = bt ? jp : njp;
                m_cnt = m_cnt + 32'd1;
            end
            e.fl = mis;
            e.npc = m_newpc;
            e.cnt = m_cnt;
            if (bx) begin
                i = m_idx(xp);
                if (m_hit(xp)) begin
                    if (bt) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_target[i] = {jp[31:2], 2'b00};
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (bt) begin
                    m_valid[i] = 1'b1;
                    m_tag[i] = m_tagof(xp);
                    m_target[i] = {jp[31:2], 2'b00};
                    m_ctr[i] = 2;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] xp, input bit bt, input logic [31:0] jp,
                           input bit ept, input logic [31:0] epp);
        step(0, 0, 0, 1, xp, jp, xp + 32'd4, bt, ept, epp);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] p;
        case ($urandom_range(0, 7))
            0: p = 32'h100;
            1: p = 32'h100 + (32'd1 << (IDX + 2));
            2: p = 32'h104;
            3: p = 32'hFFFF_FFFC;
            4: p = 32'h0000_2000;
            default: p = {$urandom_range(0, 32'h3FFF), 2'b00};
        endcase
        return p;
    endfunction

    // Monitor: every edge the DUT presents one cycle's worth of outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pred_valid", {31'b0, pred_valid}, {31'b0, e.pv});
                if (e.pv || e.rst) begin
                    chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
                    chk("pred_pc", pred_pc, e.ppc);
                end
                chk("flush", {31'b0, flush}, {31'b0, e.fl});
                if (e.fl || e.rst) chk("new_pc", new_pc, e.npc);
`ifdef BRANCH_PREDICTOR_STATS_EN
                chk("mispredict_count", mispredict_count, e.cnt);
`endif
            end
        end
    end

    initial begin
        logic [31:0] xp;
        logic [31:0] epp;
        bit bt;
        bit ept;

        // Reset with lookup and a mispredict pending: all outputs must stay clear.
        step(1, 1, 32'h100, 1, 32'h100, 32'h200, 32'h104, 1, 0, 0);
        after_edge();
        chk("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        lookup(32'h100);
        after_edge();
        chk("cold_valid", {31'b0, pred_valid}, 32'd1);
        chk("cold_pc", pred_pc, 32'h104);

        resolve(32'h100, 1, 32'h200, 0, 32'h104);
        after_edge();
        chk("alloc_flush", {31'b0, flush}, 32'd1);
        chk("alloc_new_pc", new_pc, 32'h200);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("flush_one_cycle", {31'b0, flush}, 32'd0);

        lookup(32'h100);
        after_edge();
        chk("hit_taken", {31'b0, pred_taken}, 32'd1);
        chk("hit_pc", pred_pc, 32'h200);

        resolve(32'h100, 0, 32'h200, 1, 32'h200);
        resolve(32'h100, 0, 32'h200, 0, 32'h200);
        resolve(32'h100, 0, 32'h200, 0, 32'h200);
        lookup(32'h100);
        after_edge();
        chk("sat_low_pc", pred_pc, 32'h104);

        resolve(32'h100, 1, 32'h200, 0, 32'h104);
        resolve(32'h100, 1, 32'h200, 0, 32'h104);
        resolve(32'h100, 1, 32'h300, 1, 32'h200);
        after_edge();
        chk("target_flush", {31'b0, flush}, 32'd1);
        chk("target_new_pc", new_pc, 32'h300);
        lookup(32'h100);
        after_edge();
        chk("target_updated", pred_pc, 32'h300);

        step(0, 1, 32'h100, 1, 32'h100, 32'h400, 32'h104, 1, 1, 32'h300);
        after_edge();
        chk("same_cycle_old", pred_pc, 32'h300);
        lookup(32'h100);
        after_edge();
        chk("same_cycle_new", pred_pc, 32'h400);

        lookup(32'hFFFF_FFFC);
        after_edge();
        chk("wrap_pc", pred_pc, 32'h0);

        step(1, 1, 32'h100, 1, 32'h100, 32'h500, 32'h104, 1, 0, 0);
        after_edge();
        chk("rst_cancels_flush", {31'b0, flush}, 32'd0);
        lookup(32'h100);
        after_edge();
        chk("post_rst_miss", pred_pc, 32'h104);

        for (int n = 0; n < 1500; n++) begin
            xp = pick_pc();
            bt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                m_predict(xp, ept, epp);
            end else begin
                ept = 1'($urandom_range(0, 1));
                epp = pick_pc();
            end
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), pick_pc(),
                 1'($urandom_range(0, 1)), xp, pick_pc(), xp + 32'd4, bt, ept, epp);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
